// File: rtl/rs_scheduler.sv
// rs_scheduler: reservation station between decode and one execution unit.
// Buffers decoded ops with operand values or producer tags, wakes operands
// from the CDB, picks a ready entry round-robin and issues it over a
// valid/ready handshake. A presented-but-stalled op stays locked until taken.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   disp_*              dispatch from decode (valid/ready, op, vj/vk, qj/qk, dtag)
//   cdb_*               common data bus broadcast (valid, tag, data)
//   issue_*             issue to execution unit (valid/ready, op, vj, vk, dtag)
//   count               occupied entries
//
// Optional build macro RS_FULL_BYPASS_EN: when the station is full and an
// issue fires, dispatch is accepted into the slot being issued
// (adds a combinational issue_ready -> disp_ready path).
module rs_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned OP_W  = 10,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [XLEN-1:0]            disp_vj,
  input  logic [XLEN-1:0]            disp_vk,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_qk,
  input  logic [TAG_W-1:0]           disp_dtag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [XLEN-1:0]            issue_vj,
  output logic [XLEN-1:0]            issue_vk,
  output logic [TAG_W-1:0]           issue_dtag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dtag;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;
  logic [CNT_W-1:0] count_q;

  logic [DEPTH-1:0] ready_c;
  logic [IDX_W-1:0] sel_c;
  logic             sel_valid_c;
  logic [IDX_W-1:0] free_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             full_c;
  logic             issue_fire_c;
  logic             disp_fire_c;
  entry_t           new_ent_c;

  // Entry is ready once both operands hold values (registered state only,
  // so a wakeup becomes issuable the cycle after the broadcast).
  always_comb begin
    ready_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready_c[i] = busy[i] && (ent[i].qj == '0) && (ent[i].qk == '0);
    end
  end

  // Selection: locked index holds; otherwise first ready entry from rr_ptr.
  // Scanning backwards lets the nearest-to-rr_ptr hit win the last write.
  always_comb begin
    sel_c       = lock_idx;
    sel_valid_c = 1'b0;
    if (lock) begin
      sel_valid_c = ready_c[lock_idx];
    end else begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (ready_c[rr_ptr + IDX_W'(k)]) begin
          sel_c       = rr_ptr + IDX_W'(k);
          sel_valid_c = 1'b1;
        end
      end
    end
  end

  // Lowest-index free entry for dispatch.
  always_comb begin
    free_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!busy[i]) free_c = IDX_W'(i);
    end
  end

  assign full_c       = (count_q >= CNT_W'(DEPTH));
  assign issue_fire_c = sel_valid_c && issue_ready;

`ifdef RS_FULL_BYPASS_EN
  assign disp_ready = !full_c || issue_fire_c;
  assign wr_idx_c   = full_c ? sel_c : free_c;
`else
  assign disp_ready = !full_c;
  assign wr_idx_c   = free_c;
`endif

  assign disp_fire_c = disp_valid && disp_ready;

  // Incoming entry with same-cycle CDB forwarding so a broadcast during
  // dispatch is not missed.
  always_comb begin
    new_ent_c.op   = disp_op;
    new_ent_c.vj   = disp_vj;
    new_ent_c.vk   = disp_vk;
    new_ent_c.qj   = disp_qj;
    new_ent_c.qk   = disp_qk;
    new_ent_c.dtag = disp_dtag;
    if (cdb_valid && (disp_qj != '0) && (cdb_tag == disp_qj)) begin
      new_ent_c.vj = cdb_data;
      new_ent_c.qj = '0;
    end
    if (cdb_valid && (disp_qk != '0) && (cdb_tag == disp_qk)) begin
      new_ent_c.vk = cdb_data;
      new_ent_c.qk = '0;
    end
  end

  // Issue payload, zeroed when nothing is presented.
  assign issue_valid = sel_valid_c;
  assign issue_op    = sel_valid_c ? ent[sel_c].op   : '0;
  assign issue_vj    = sel_valid_c ? ent[sel_c].vj   : '0;
  assign issue_vk    = sel_valid_c ? ent[sel_c].vk   : '0;
  assign issue_dtag  = sel_valid_c ? ent[sel_c].dtag : '0;
  assign count       = count_q;

  // State update: wakeup, then issue retire/lock, then dispatch write
  // (the dispatch write wins when it reuses the issuing slot).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (busy[i] && cdb_valid) begin
          if ((ent[i].qj != '0) && (ent[i].qj == cdb_tag)) begin
            ent[i].vj <= cdb_data;
            ent[i].qj <= '0;
          end
          if ((ent[i].qk != '0) && (ent[i].qk == cdb_tag)) begin
            ent[i].vk <= cdb_data;
            ent[i].qk <= '0;
          end
        end
      end

      if (issue_fire_c) begin
        busy[sel_c] <= 1'b0;
        rr_ptr      <= sel_c + IDX_W'(1);
        lock        <= 1'b0;
      end else if (sel_valid_c) begin
        lock     <= 1'b1;
        lock_idx <= sel_c;
      end

      if (disp_fire_c) begin
        busy[wr_idx_c] <= 1'b1;
        ent[wr_idx_c]  <= new_ent_c;
      end

      case ({disp_fire_c, issue_fire_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// tb_rs_scheduler: table-driven, hand-sequenced and randomized checks of
// rs_scheduler against a behavioural station model.
module tb_rs_scheduler;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int OP_W  = 10;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             disp_valid, disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj, disp_vk;
  logic [TAG_W-1:0] disp_qj, disp_qk, disp_dtag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             issue_valid, issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [XLEN-1:0]  issue_vj, issue_vk;
  logic [TAG_W-1:0] issue_dtag;
  logic [2:0]       count;

  always #5 clk = ~clk;

  rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_dtag(disp_dtag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_dtag(issue_dtag),
    .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit               busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj, vk;
    logic [TAG_W-1:0] qj, qk, dtag;
  } ment_t;

  ment_t m [DEPTH];
  int    m_rr;
  bit    m_lock;
  int    m_lidx;
  bit    e_valid;
  int    e_sel;
  bit    e_dready;
  int    e_count;

  function automatic void model_eval();
    e_count = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) e_count++;
    e_valid = 1'b0;
    e_sel   = 0;
    if (m_lock) begin
      e_valid = 1'b1;
      e_sel   = m_lidx;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        int i;
        i = (m_rr + k) % DEPTH;
        if (!e_valid && m[i].busy && m[i].qj == 0 && m[i].qk == 0) begin
          e_valid = 1'b1;
          e_sel   = i;
        end
      end
    end
    e_dready = (e_count < DEPTH);
`ifdef RS_FULL_BYPASS_EN
    if (e_valid && issue_ready) e_dready = 1'b1;
`endif
  endfunction

  function automatic void model_update();
    bit ifire, dfire;
    int widx;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
      m_rr = 0; m_lock = 1'b0; m_lidx = 0;
      return;
    end
    ifire = e_valid && issue_ready;
    dfire = disp_valid && e_dready;
    widx = -1;
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy && widx < 0) widx = i;
    if (widx < 0) widx = e_sel;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && cdb_valid) begin
        if (m[i].qj != 0 && m[i].qj == cdb_tag) begin m[i].vj = cdb_data; m[i].qj = 0; end
        if (m[i].qk != 0 && m[i].qk == cdb_tag) begin m[i].vk = cdb_data; m[i].qk = 0; end
      end
    end
    if (ifire) begin
      m[e_sel].busy = 1'b0;
      m_rr   = (e_sel + 1) % DEPTH;
      m_lock = 1'b0;
    end else if (e_valid) begin
      m_lock = 1'b1;
      m_lidx = e_sel;
    end
    if (dfire) begin
      m[widx].busy = 1'b1;
      m[widx].op   = disp_op;
      m[widx].vj   = disp_vj;
      m[widx].vk   = disp_vk;
      m[widx].qj   = disp_qj;
      m[widx].qk   = disp_qk;
      m[widx].dtag = disp_dtag;
      if (cdb_valid && disp_qj != 0 && cdb_tag == disp_qj) begin m[widx].vj = cdb_data; m[widx].qj = 0; end
      if (cdb_valid && disp_qk != 0 && cdb_tag == disp_qk) begin m[widx].vk = cdb_data; m[widx].qk = 0; end
    end
  endfunction

  task automatic compare_model();
    model_eval();
    chk("m_issue_valid", 32'(issue_valid), 32'(e_valid));
    chk("m_disp_ready", 32'(disp_ready), 32'(e_dready));
    chk("m_count", 32'(count), 32'(e_count));
    chk("m_issue_op", 32'(issue_op), e_valid ? 32'(m[e_sel].op) : 32'd0);
    chk("m_issue_vj", issue_vj, e_valid ? m[e_sel].vj : 32'd0);
    chk("m_issue_vk", issue_vk, e_valid ? m[e_sel].vk : 32'd0);
    chk("m_issue_dtag", 32'(issue_dtag), e_valid ? 32'(m[e_sel].dtag) : 32'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic settle();  #2; compare_model(); endtask
  task automatic advance(); model_update(); @(posedge clk); #1; endtask
  task automatic tick();    settle(); advance(); endtask

  task automatic set_disp(input bit v, input logic [9:0] op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [4:0] qj,
                          input logic [4:0] qk, input logic [4:0] dtag);
    disp_valid = v; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj = qj; disp_qk = qk; disp_dtag = dtag;
  endtask

  task automatic set_cdb(input bit v, input logic [4:0] tag, input logic [31:0] data);
    cdb_valid = v; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic idle();
    set_disp(1'b0, '0, '0, '0, '0, '0, '0);
    set_cdb(1'b0, '0, '0);
  endtask

  typedef struct {
    bit dv; logic [9:0] op; logic [31:0] vj, vk; logic [4:0] qj, qk, dtag;
    bit cv; logic [4:0] ctag; logic [31:0] cdata; bit ir;
    bit x_valid; logic [31:0] x_vj; logic [4:0] x_dtag; int x_count;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit dv, input logic [9:0] op, input logic [31:0] vj,
                     input logic [31:0] vk, input logic [4:0] qj, input logic [4:0] qk,
                     input logic [4:0] dtag, input bit cv, input logic [4:0] ctag,
                     input logic [31:0] cdata, input bit ir, input bit xv,
                     input logic [31:0] xvj, input logic [4:0] xdt, input int xc);
    vec_t v;
    v.dv = dv; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk; v.dtag = dtag;
    v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.ir = ir;
    v.x_valid = xv; v.x_vj = xvj; v.x_dtag = xdt; v.x_count = xc;
    vq.push_back(v);
  endtask

  initial begin
    // idle after reset
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // ready op straight through
    add(1, 10'h033, 5, 7, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // waiting on tag 4, woken two cycles after dispatch
    add(1, 10'h001, 0, 9, 4, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hDEAD, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD, 6, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // broadcast in the dispatch cycle
    add(1, 10'h002, 0, 8, 4, 0, 7, 1, 4, 32'hBEEF, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBEEF, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    reset = 1'b1; issue_ready = 1'b0; idle();
    @(posedge clk); #1;
    model_update();
    reset = 1'b0;

    // ---- table-driven vectors ----
    foreach (vq[n]) begin
      set_disp(vq[n].dv, vq[n].op, vq[n].vj, vq[n].vk, vq[n].qj, vq[n].qk, vq[n].dtag);
      set_cdb(vq[n].cv, vq[n].ctag, vq[n].cdata);
      issue_ready = vq[n].ir;
      settle();
      chk($sformatf("v%0d_issue_valid", n), 32'(issue_valid), 32'(vq[n].x_valid));
      chk($sformatf("v%0d_issue_vj", n), issue_vj, vq[n].x_vj);
      chk($sformatf("v%0d_issue_dtag", n), 32'(issue_dtag), 32'(vq[n].x_dtag));
      chk($sformatf("v%0d_count", n), 32'(count), 32'(vq[n].x_count));
      chk($sformatf("v%0d_disp_ready", n), 32'(disp_ready), 32'd1);
      advance();
    end

    // ---- fill, hold locked payload while others wake, drain in order ----
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    issue_ready = 1'b0;
    set_disp(1, 10'h100, 32'h100, 0, 0, 0, 20);    tick();
    set_disp(1, 10'h101, 32'h101, 0, 0, 0, 21);    tick();
    set_disp(1, 10'h102, 0, 0, 9, 0, 22);          tick();
    set_disp(1, 10'h103, 32'h103, 0, 0, 10, 23);   tick();
    idle(); set_cdb(1, 9, 32'h999);
    settle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("lock_valid", 32'(issue_valid), 32'd1);
    chk("lock_dtag0", 32'(issue_dtag), 32'd20);
    advance();
    set_cdb(1, 10, 32'hAAA);
    settle(); chk("lock_dtag1", 32'(issue_dtag), 32'd20); chk("lock_vj1", issue_vj, 32'h100); advance();
    idle();
    settle(); chk("lock_dtag2", 32'(issue_dtag), 32'd20); advance();
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("drain%0d_valid", k), 32'(issue_valid), 32'd1);
      chk($sformatf("drain%0d_dtag", k), 32'(issue_dtag), 32'(20 + k));
      if (k == 2) chk("drain2_woken_vj", issue_vj, 32'h999);
      if (k == 3) chk("drain3_woken_vk", issue_vk, 32'hAAA);
      advance();
    end
    settle(); chk("drained_valid", 32'(issue_valid), 32'd0); chk("drained_count", 32'(count), 32'd0); advance();

    // ---- full station with issue firing and dispatch pending ----
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(1, 10'(k), 32'(k), 0, 0, 0, 5'(24 + k)); tick();
    end
    set_disp(1, 10'h1AB, 32'h55, 0, 0, 0, 28);
    issue_ready = 1'b1;
    settle();
    chk("byp_count_full", 32'(count), 32'd4);
`ifdef RS_FULL_BYPASS_EN
    chk("byp_disp_ready", 32'(disp_ready), 32'd1);
    advance();
    idle(); issue_ready = 1'b0;
    settle(); chk("byp_count_after", 32'(count), 32'd4); advance();
`else
    chk("byp_disp_ready", 32'(disp_ready), 32'd0);
    advance();
    issue_ready = 1'b0;
    settle(); chk("byp_disp_ready_next", 32'(disp_ready), 32'd1); chk("byp_count_mid", 32'(count), 32'd3); advance();
    idle();
    settle(); chk("byp_count_after", 32'(count), 32'd4); advance();
`endif
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle(); chk($sformatf("byp_drain%0d_dtag", k), 32'(issue_dtag), 32'(25 + k)); advance();
    end

    // ---- reset with busy entries and a locked issue ----
    issue_ready = 1'b0;
    set_disp(1, 10'h0C1, 1, 1, 0, 0, 1);  tick();
    set_disp(1, 10'h0C2, 0, 1, 13, 0, 2); tick();
    set_disp(1, 10'h0C3, 0, 1, 13, 0, 3); tick();
    idle();
    settle(); chk("pre_rst_count", 32'(count), 32'd3); chk("pre_rst_valid", 32'(issue_valid), 32'd1); advance();
    reset = 1'b1; issue_ready = 1'b1; tick(); reset = 1'b0;
    settle(); chk("rst_count", 32'(count), 32'd0); chk("rst_valid", 32'(issue_valid), 32'd0); advance();
    set_cdb(1, 13, 32'h1313); tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      settle(); chk($sformatf("rst_cdb%0d_valid", k), 32'(issue_valid), 32'd0); advance();
    end

    // ---- randomized against the model ----
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 200) == 0;
      set_disp(1'($urandom % 2), 10'($urandom), $urandom, $urandom,
               ($urandom % 3 == 0) ? 5'($urandom_range(1, 6)) : 5'd0,
               ($urandom % 3 == 0) ? 5'($urandom_range(1, 6)) : 5'd0,
               5'($urandom));
      set_cdb(($urandom % 3) == 0, 5'($urandom_range(1, 6)), $urandom);
      issue_ready = ($urandom % 4) != 0;
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
